// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream_mux_rr block.
package stream_mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  // Upper bound on channel count supported by the round-robin helper.
  localparam int unsigned MaxChan = 32;

  // First valid channel scanning upward from last+1, wrapping at n; -1 if none is valid.
  function automatic int rr_pick(input logic [MaxChan-1:0] valid, input int unsigned last,
                                 input int unsigned n);
    int          pick;
    int unsigned idx;
    pick = -1;
    for (int unsigned k = 1; k <= MaxChan; k++) begin
      idx = (last + k) % n;
      if (k <= n && pick < 0 && valid[idx]) pick = int'(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Handshake bundle for stream_mux_rr: N input streams merged into one output stream.
// With STREAM_MUX_LAST_EN defined, in_last/out_last carry packet boundaries.
interface stream_mux_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  localparam int unsigned SW = $clog2(N);

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_ready;
`ifdef STREAM_MUX_LAST_EN
  logic [N-1:0]   in_last;
  logic           out_last;
`endif

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, sel, out_ready,
    input  in_ready, out_valid, out_data, out_chan
`ifdef STREAM_MUX_LAST_EN
    , output in_last, input out_last
`endif
  );

  // Multiplexer side.
  modport slave (
    input  in_valid, in_data, sel, out_ready,
    output in_ready, out_valid, out_data, out_chan
`ifdef STREAM_MUX_LAST_EN
    , input in_last, output out_last
`endif
  );

endinterface

// File: rtl/rr_arbiter.sv
// N-way round-robin pointer arbiter: combinational pick from the valid vector,
// registered index of the last granted channel. Resets so channel 0 wins first.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  valid,
  input  logic          update,
  input  logic [SW-1:0] upd_idx,
  output logic [SW-1:0] pick
);

  localparam logic [SW-1:0] LastRst = SW'(N - 1);

  logic [SW-1:0] last_q;
  int unsigned   last_u;
  int            pick_raw;

  // Pick is only meaningful when some channel is valid; the caller re-checks valid.
  always_comb begin
    last_u   = 32'(last_q);
    pick_raw = rr_pick(MaxChan'(valid), last_u, N);
    pick     = SW'(pick_raw);
  end

  // Remember the most recently granted channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= LastRst;
    end else if (update) begin
      last_q <= upd_idx;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-input stream multiplexer with a registered output slot. Channel choice is
// external (MODE_SEL) or round-robin (MODE_RR). Define STREAM_MUX_LAST_EN to add
// packet locking via in_last/out_last.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int unsigned N    = 4,
  parameter  int unsigned W    = 8,
  parameter  mode_e       MODE = MODE_RR,
  localparam int unsigned SW   = $clog2(N)
) (
  input logic       clk,
  input logic       rst,
  stream_mux_if.slave bus
);

  logic          slot_free;
  logic          cand_ok;
  logic          grant;
  logic [SW-1:0] cand;
  logic [SW-1:0] rr_idx;
  logic [W-1:0]  cand_data;
  logic          cand_last;

  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_chan_q;
`ifdef STREAM_MUX_LAST_EN
  logic          lock_q;
  logic [SW-1:0] lock_chan_q;
  logic          out_last_q;
`endif

  if (MODE == MODE_RR) begin : g_rr
    rr_arbiter #(
      .N(N)
    ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .valid  (bus.in_valid),
      .update (grant),
      .upd_idx(cand),
      .pick   (rr_idx)
    );
  end else begin : g_sel
    assign rr_idx = '0;
  end

  // Candidate channel selection; an open packet overrides both select modes.
  always_comb begin
    cand = (MODE == MODE_RR) ? rr_idx : bus.sel;
`ifdef STREAM_MUX_LAST_EN
    if (lock_q) cand = lock_chan_q;
`endif
  end

  // Fetch the candidate's beat; an out-of-range select matches nothing and stays idle.
  always_comb begin
    cand_ok   = 1'b0;
    cand_data = '0;
    cand_last = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (cand == SW'(i)) begin
        cand_ok   = bus.in_valid[i];
        cand_data = bus.in_data[i*W +: W];
`ifdef STREAM_MUX_LAST_EN
        cand_last = bus.in_last[i];
`endif
      end
    end
  end

  // Grant and one-hot ready; nothing is accepted while reset is asserted.
  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    grant     = slot_free && cand_ok && !rst;
    for (int i = 0; i < int'(N); i++) begin
      bus.in_ready[i] = grant && (cand == SW'(i));
    end
  end

  // Output slot: reload on grant, empty when free with no grant, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else if (slot_free) begin
      out_valid_q <= grant;
      if (grant) begin
        out_data_q <= cand_data;
        out_chan_q <= cand;
      end
    end
  end

`ifdef STREAM_MUX_LAST_EN
  // Packet lock: stay on a channel until its last beat has been accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q      <= 1'b0;
      lock_chan_q <= '0;
      out_last_q  <= 1'b0;
    end else if (grant) begin
      lock_q      <= !cand_last;
      lock_chan_q <= cand;
      out_last_q  <= cand_last;
    end
  end

  assign bus.out_last = out_last_q;
`else
  logic unused_last;
  assign unused_last = cand_last;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: a round-robin DUT (N=4) and an
// external-select DUT (N=5) against a queue-free behavioural model of the rules.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_mux_if #(.N(4), .W(W)) bus_rr ();
  stream_mux_if #(.N(5), .W(W)) bus_sel ();

  stream_mux_rr #(.N(4), .W(W), .MODE(MODE_RR)) u_rr (
    .clk(clk), .rst(rst), .bus(bus_rr)
  );
  stream_mux_rr #(.N(5), .W(W), .MODE(MODE_SEL)) u_sel (
    .clk(clk), .rst(rst), .bus(bus_sel)
  );

  int total = 0;
  int bad   = 0;
  bit rand_mode = 1'b0;

  // Stimulus mirror per DUT (0 = round-robin, 1 = select).
  int nch[2]   = '{4, 5};
  bit is_rr[2] = '{1'b1, 1'b0};
  bit pv[2][8];
  int pd[2][8];
  bit pl[2][8];
  int sel_v[2];
  bit ordy[2];
  bit hs[2][8];

  // Model state.
  bit m_ov[2];
  int m_od[2];
  int m_oc[2];
  int m_last[2];
  bit m_lock[2];
  int m_lockch[2];
  bit m_ol[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int d);
    m_ov[d] = 0; m_od[d] = 0; m_oc[d] = 0; m_last[d] = nch[d] - 1;
    m_lock[d] = 0; m_lockch[d] = 0; m_ol[d] = 0;
  endtask

  function automatic int m_pick(input int d);
    int idx;
    if (m_lock[d]) return pv[d][m_lockch[d]] ? m_lockch[d] : -1;
    if (is_rr[d]) begin
      for (int k = 1; k <= nch[d]; k++) begin
        idx = (m_last[d] + k) % nch[d];
        if (pv[d][idx]) return idx;
      end
      return -1;
    end
    if (sel_v[d] < nch[d] && pv[d][sel_v[d]]) return sel_v[d];
    return -1;
  endfunction

  function automatic logic [7:0] exp_ready(input int d);
    logic [7:0] r;
    int c;
    r = '0;
    c = m_pick(d);
    if (!rst && (!m_ov[d] || ordy[d]) && c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      bus_rr.in_valid[i]       = pv[0][i];
      bus_rr.in_data[i*W +: W] = 8'(pd[0][i]);
`ifdef STREAM_MUX_LAST_EN
      bus_rr.in_last[i]        = pl[0][i];
`endif
    end
    for (int i = 0; i < 5; i++) begin
      bus_sel.in_valid[i]       = pv[1][i];
      bus_sel.in_data[i*W +: W] = 8'(pd[1][i]);
`ifdef STREAM_MUX_LAST_EN
      bus_sel.in_last[i]        = pl[1][i];
`endif
    end
    bus_rr.sel        = 2'(sel_v[0]);
    bus_sel.sel       = 3'(sel_v[1]);
    bus_rr.out_ready  = ordy[0];
    bus_sel.out_ready = ordy[1];
  endtask

  task automatic check_all();
    chk("rr_in_ready", 64'(bus_rr.in_ready), 64'(exp_ready(0)));
    chk("rr_out_valid", 64'(bus_rr.out_valid), 64'(m_ov[0]));
    chk("rr_out_data", 64'(bus_rr.out_data), 64'(m_od[0]));
    chk("rr_out_chan", 64'(bus_rr.out_chan), 64'(m_oc[0]));
    chk("sel_in_ready", 64'(bus_sel.in_ready), 64'(exp_ready(1)));
    chk("sel_out_valid", 64'(bus_sel.out_valid), 64'(m_ov[1]));
    chk("sel_out_data", 64'(bus_sel.out_data), 64'(m_od[1]));
    chk("sel_out_chan", 64'(bus_sel.out_chan), 64'(m_oc[1]));
`ifdef STREAM_MUX_LAST_EN
    chk("rr_out_last", 64'(bus_rr.out_last), 64'(m_ol[0]));
    chk("sel_out_last", 64'(bus_sel.out_last), 64'(m_ol[1]));
`endif
  endtask

  task automatic model_update();
    int c;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) hs[d][i] = 1'b0;
      if (rst) begin
        model_reset(d);
      end else if (!m_ov[d] || ordy[d]) begin
        c = m_pick(d);
        if (c >= 0) begin
          m_ov[d] = 1; m_od[d] = pd[d][c]; m_oc[d] = c; hs[d][c] = 1'b1;
          if (is_rr[d]) m_last[d] = c;
`ifdef STREAM_MUX_LAST_EN
          m_lock[d] = !pl[d][c]; m_lockch[d] = c; m_ol[d] = pl[d][c];
`endif
        end else begin
          m_ov[d] = 0;
        end
      end
    end
  endtask

  task automatic producers_update();
    if (!rand_mode) return;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < nch[d]; i++) begin
        if (hs[d][i] || (!pv[d][i] && $urandom_range(0, 2) == 0)) begin
          pv[d][i] = hs[d][i] ? 1'($urandom_range(0, 1)) : 1'b1;
          pd[d][i] = int'($urandom_range(0, 255));
          pl[d][i] = 1'($urandom_range(0, 1));
        end
      end
      ordy[d] = ($urandom_range(0, 3) != 0);
    end
    sel_v[0] = int'($urandom_range(0, 3));
    sel_v[1] = int'($urandom_range(0, 7));
    rst = ($urandom_range(0, 127) == 0);
  endtask

  // One clock: check before the edge, advance the model on it, restimulate after it.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
    producers_update();
    apply();
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        pv[d][i] = 0; pd[d][i] = 0; pl[d][i] = 0;
      end
      sel_v[d] = 0; ordy[d] = 1; model_reset(d);
    end
    apply();
    @(negedge clk);
    step();
    step();
    chk("rst_out_valid", 64'(bus_rr.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus_rr.in_ready), 64'd0);

    // All four channels valid: strict 0,1,2,3,0 rotation, one per cycle.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pv[0][i] = 1; pd[0][i] = 16 + i;
    end
    apply();
    #1 chk("p1_first_ready", 64'(bus_rr.in_ready), 64'h1);
    step();
    for (int k = 0; k < 6; k++) begin
      chk("p1_chan", 64'(bus_rr.out_chan), 64'(k % 4));
      chk("p1_data", 64'(bus_rr.out_data), 64'(16 + k % 4));
      if (k < 5) step();
    end

    // Backpressure holds the slot and blocks every input.
    ordy[0] = 0;
    apply();
    #1 chk("bp_ready", 64'(bus_rr.in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_valid", 64'(bus_rr.out_valid), 64'd1);
      chk("bp_chan", 64'(bus_rr.out_chan), 64'd1);
      chk("bp_data", 64'(bus_rr.out_data), 64'h11);
    end
    ordy[0] = 1;
    apply();
    #1 chk("bp_release_ready", 64'(bus_rr.in_ready), 64'h4);
    step();
    chk("bp_release_chan", 64'(bus_rr.out_chan), 64'd2);

    // Only channel 2 valid, then channel 0 joins: alternate 0,2.
    for (int i = 0; i < 4; i++) pv[0][i] = 0;
    pv[0][2] = 1; pd[0][2] = 'hA5;
    apply();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("solo_chan", 64'(bus_rr.out_chan), 64'd2);
      chk("solo_data", 64'(bus_rr.out_data), 64'hA5);
    end
    pv[0][0] = 1;
    apply();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("alt_chan", 64'(bus_rr.out_chan), (k % 2 == 0) ? 64'd0 : 64'd2);
    end

    // Reset with a beat in the slot discards it; channel 0 wins afterwards.
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 64'(bus_rr.out_valid), 64'd0);
    chk("mid_rst_data", 64'(bus_rr.out_data), 64'd0);
    chk("mid_rst_chan", 64'(bus_rr.out_chan), 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_valid", 64'(bus_rr.out_valid), 64'd1);
    chk("post_rst_chan", 64'(bus_rr.out_chan), 64'd0);

    // External select: only the selected channel is readied; out-of-range idles.
    pv[1][0] = 1; pd[1][0] = 'h33;
    pv[1][3] = 1; pd[1][3] = 'h7E;
    sel_v[1] = 3; ordy[1] = 1;
    apply();
    #1 chk("sel3_ready", 64'(bus_sel.in_ready), 64'h08);
    step();
    chk("sel3_data", 64'(bus_sel.out_data), 64'h7E);
    chk("sel3_chan", 64'(bus_sel.out_chan), 64'd3);
    sel_v[1] = 6;
    apply();
    #1 chk("sel6_ready", 64'(bus_sel.in_ready), 64'd0);
    step();
    chk("sel6_valid", 64'(bus_sel.out_valid), 64'd0);

`ifdef STREAM_MUX_LAST_EN
    // Channel 1 packet of three beats keeps the grant although channel 0 waits.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) pv[0][i] = 0;
    apply();
    step();
    rst = 1'b0;
    pv[0][1] = 1; pd[0][1] = 'h21; pl[0][1] = 0;
    apply();
    step();
    chk("pkt_beat0", 64'(bus_rr.out_chan), 64'd1);
    pv[0][0] = 1;
    apply();
    step();
    chk("pkt_beat1", 64'(bus_rr.out_chan), 64'd1);
    pl[0][1] = 1;
    apply();
    step();
    chk("pkt_beat2", 64'(bus_rr.out_chan), 64'd1);
    chk("pkt_out_last", 64'(bus_rr.out_last), 64'd1);
    step();
    chk("pkt_next", 64'(bus_rr.out_chan), 64'd0);
`endif

    // Randomised traffic, backpressure, select and occasional reset.
    rand_mode = 1'b1;
    rst = 1'b0;
    repeat (3000) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
